// File: rtl/decode_stage.sv
// Decode/sequencing stage: strobes fetch, splits the fetched instruction into
// registered fields and hands them to execute over a valid/ready handshake.
module decode_stage #(
    parameter int         INSTR_W     = 16,
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter logic [3:0] NOP_OPCODE  = 4'h0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               activate_fetch,
    output logic               dec_valid,
    input  logic               exec_ready,
    output logic [3:0]         dec_opcode,
    output logic [3:0]         dec_rd,
    output logic [3:0]         dec_rs1,
    output logic [3:0]         dec_rs2,
    output logic [7:0]         dec_imm,
    output logic               dec_uses_imm,
    output logic               dec_wr_en,
    output logic               dec_is_mem,
    output logic               dec_is_branch,
    output logic               halted,
    output logic               illegal
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        ISSUE  = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0] opcode;
    logic       op_is_nop;
    logic       op_is_halt;
    logic       op_is_illegal;
    logic       load_fields;

    assign opcode        = instr_in[15:12];
    assign op_is_nop     = (opcode == NOP_OPCODE);
    assign op_is_halt    = (opcode == HALT_OPCODE);
    assign op_is_illegal = (opcode inside {[4'hB:4'hE]});
    assign load_fields   = (state == DECODE) && !op_is_nop && !op_is_halt && !op_is_illegal;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run) state_next = FETCH;
            FETCH:   state_next = DECODE;
            DECODE: begin
                if (op_is_nop)                       state_next = run ? FETCH : IDLE;
                else if (op_is_halt || op_is_illegal) state_next = HALT;
                else                                  state_next = ISSUE;
            end
            ISSUE:   if (exec_ready) state_next = run ? FETCH : IDLE;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs follow the state directly, so an async
    // reset clears them in the same instant it clears the state.
    always_comb begin
        activate_fetch = (state == FETCH);
        dec_valid      = (state == ISSUE);
        halted         = (state == HALT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            illegal <= 1'b0;
        end else if ((state == DECODE) && op_is_illegal) begin
            illegal <= 1'b1;
        end
    end

    // Fields are written only by a real issue; NOP/HALT leave the previous values in place.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec_opcode    <= 4'h0;
            dec_rd        <= 4'h0;
            dec_rs1       <= 4'h0;
            dec_rs2       <= 4'h0;
            dec_imm       <= 8'h00;
            dec_uses_imm  <= 1'b0;
            dec_wr_en     <= 1'b0;
            dec_is_mem    <= 1'b0;
            dec_is_branch <= 1'b0;
        end else if (load_fields) begin
            dec_opcode    <= opcode;
            dec_rd        <= instr_in[11:8];
            dec_rs1       <= instr_in[7:4];
            dec_rs2       <= instr_in[3:0];
            dec_imm       <= instr_in[7:0];
            dec_uses_imm  <= (opcode == 4'h6) || (opcode == 4'h9);
            dec_wr_en     <= (opcode >= 4'h1) && (opcode <= 4'h7);
            dec_is_mem    <= (opcode == 4'h7) || (opcode == 4'h8);
            dec_is_branch <= (opcode == 4'h9) || (opcode == 4'hA);
        end
    end

endmodule
